// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] adr;
        logic              we;
        logic [WORD_W-1:0] wdata;
    } req_t;

    // A byte address is bad if it is not word aligned or past the last word.
    function automatic logic addr_error(input logic [WORD_W-1:0] a, input int unsigned depth);
        return (a[1:0] != 2'b00) || ({2'b00, a[WORD_W-1:2]} >= WORD_W'(depth));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM; read data is held until the next read.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_W-1:0]              din,
    output logic [WORD_W-1:0]              dout
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // One access per enabled edge: write the word, or capture it on dout.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed shared instruction/data memory with req/ready handshake
// and a fixed number of wait states between acceptance and response.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] adr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              err
);

    localparam int unsigned       AW       = $clog2(DEPTH_WORDS);
    localparam bit                NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [WAIT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state, state_next;
    logic [WAIT_W-1:0] cnt, cnt_next;
    req_t              lat, lat_next;
    req_t              cur;
    logic              ready_next, err_next;
    logic              zero, zero_next;
    logic              enter_resp;
    logic              cur_err;
    logic              ram_en, ram_we;
    logic [WORD_W-1:0] ram_dout;

    // Request in effect: live inputs while idle (zero-wait case), latched copy otherwise.
    always_comb begin
        cur = lat;
        if (state == IDLE) begin
            cur.adr   = adr;
            cur.we    = we;
            cur.wdata = wdata;
        end
    end

    assign cur_err = addr_error(cur.adr, DEPTH_WORDS);

    // Next state, wait counter, request latch and response flags.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lat_next   = lat;
        ready_next = 1'b0;
        err_next   = 1'b0;
        zero_next  = zero;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    lat_next = cur;
                    if (NO_WAIT) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - WAIT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (enter_resp) begin
            ready_next = 1'b1;
            err_next   = cur_err;
            if (cur_err) begin
                zero_next = 1'b1;
            end else if (!cur.we) begin
                zero_next = 1'b0;
            end
        end
    end

    // State register and all response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
            zero  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lat   <= lat_next;
            ready <= ready_next;
            err   <= err_next;
            zero  <= zero_next;
        end
    end

    assign ram_en = enter_resp && !cur_err;
    assign ram_we = ram_en && cur.we;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk (clk),
        .en  (ram_en),
        .we  (ram_we),
        .addr(cur.adr[AW+1:2]),
        .din (cur.wdata),
        .dout(ram_dout)
    );

    // Both mux inputs and the select are flops; zero covers reset and error responses.
    assign rdata = zero ? '0 : ram_dout;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (0 and 2 wait states) against a word-array model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] adr_s   [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        ready_s [2];
    logic        err_s   [2];

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m  [2][DEPTH];
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .adr(adr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .adr(adr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1])
    );

    function automatic int wc(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    function automatic bit model_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    // One full transaction on instance s; inputs are scrambled while it is in flight.
    task automatic do_txn(input int s, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          n;
        bit          e;
        int unsigned wi;
        e  = model_err(a);
        wi = a / 4;
        @(negedge clk);
        req_s[s] = 1'b1; we_s[s] = w; adr_s[s] = a; wdata_s[s] = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                req_s[s] = 1'b0; we_s[s] = 1'($urandom);
                adr_s[s] = $urandom; wdata_s[s] = $urandom;
            end
            if (!ready_s[s]) begin
                checks++;
                if (rdata_s[s] !== exp_rd[s]) begin
                    errors++;
                    $display("FAIL %s hold: rdata=%h expected %h", tag, rdata_s[s], exp_rd[s]);
                end
            end
        end while (!ready_s[s] && n < 40);
        checks++;
        if (n != wc(s) + 1 || ready_s[s] !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got %0d ready=%b expected %0d", tag, n, ready_s[s], wc(s) + 1);
        end
        if (e) exp_rd[s] = 32'h0;
        else if (w) mem_m[s][wi] = d;
        else exp_rd[s] = mem_m[s][wi];
        checks++;
        if (err_s[s] !== e) begin
            errors++;
            $display("FAIL %s err: got %b expected %b", tag, err_s[s], e);
        end
        checks++;
        if (rdata_s[s] !== exp_rd[s]) begin
            errors++;
            $display("FAIL %s rdata: got %h expected %h", tag, rdata_s[s], exp_rd[s]);
        end
        @(posedge clk); #1;
        checks++;
        if (ready_s[s] !== 1'b0 || rdata_s[s] !== exp_rd[s]) begin
            errors++;
            $display("FAIL %s after: ready=%b rdata=%h expected 0 / %h", tag, ready_s[s], rdata_s[s], exp_rd[s]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0; we_s[s] = 1'b0; adr_s[s] = '0; wdata_s[s] = '0; exp_rd[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ready_s[s] !== 1'b0 || err_s[s] !== 1'b0 || rdata_s[s] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state[%0d]: ready=%b err=%b rdata=%h expected 0", s, ready_s[s], err_s[s], rdata_s[s]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_prefill();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++)
                do_txn(s, 1'b1, 32'(i * 4), $urandom, "prefill");
    endtask

    task automatic test_read_wait();
        do_txn(1, 1'b1, 32'h14, 32'hDEADBEEF, "wr_word5");
        do_txn(1, 1'b0, 32'h14, 32'h0, "rd_word5");
        checks++;
        if (rdata_s[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_word5_const: rdata=%h expected deadbeef", rdata_s[1]);
        end
    endtask

    task automatic test_write_read();
        do_txn(0, 1'b1, 32'h20, 32'h12345678, "wr_20");
        do_txn(0, 1'b0, 32'h20, 32'h0, "rd_20");
        checks++;
        if (rdata_s[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_20_const: rdata=%h expected 12345678", rdata_s[0]);
        end
    endtask

    task automatic test_misaligned();
        do_txn(0, 1'b1, 32'h22, 32'hFFFFFFFF, "misaligned");
        do_txn(0, 1'b0, 32'h20, 32'h0, "rd_20_after_mis");
        checks++;
        if (rdata_s[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL mis_no_write: rdata=%h expected 12345678", rdata_s[0]);
        end
    endtask

    task automatic test_out_of_range();
        do_txn(0, 1'b0, 32'h00001000, 32'h0, "oob_rd0");
        do_txn(1, 1'b0, 32'h00001000, 32'h0, "oob_rd1");
        do_txn(1, 1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, "oob_wr1");
        do_txn(1, 1'b0, 32'h00000FFC, 32'h0, "last_word_rd");
    endtask

    task automatic test_latching();
        do_txn(1, 1'b1, 32'h40, 32'hCAFEF00D, "latch_wr");
        do_txn(1, 1'b0, 32'h40, 32'h0, "latch_rd");
        do_txn(0, 1'b0, 32'h14, 32'h0, "latch_rd0");
    endtask

    // Request held high through ready starts a second transaction right after RESP.
    task automatic test_back_to_back(input int s);
        int          n, m;
        logic [31:0] d2;
        d2 = $urandom;
        @(negedge clk);
        req_s[s] = 1'b1; we_s[s] = 1'b0; adr_s[s] = 32'h0C;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!ready_s[s]) begin we_s[s] = 1'b1; adr_s[s] = $urandom; end
        end while (!ready_s[s] && n < 40);
        exp_rd[s] = mem_m[s][3];
        checks++;
        if (n != wc(s) + 1 || rdata_s[s] !== exp_rd[s]) begin
            errors++;
            $display("FAIL b2b_first[%0d]: lat=%0d rdata=%h expected %0d / %h", s, n, rdata_s[s], wc(s) + 1, exp_rd[s]);
        end
        we_s[s] = 1'b1; adr_s[s] = 32'h1C; wdata_s[s] = d2;
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
        end while (!ready_s[s] && m < 40);
        req_s[s] = 1'b0;
        mem_m[s][7] = d2;
        checks++;
        if (m != wc(s) + 2 || err_s[s] !== 1'b0 || rdata_s[s] !== exp_rd[s]) begin
            errors++;
            $display("FAIL b2b_second[%0d]: gap=%0d err=%b rdata=%h expected %0d / 0 / %h", s, m, err_s[s], rdata_s[s], wc(s) + 2, exp_rd[s]);
        end
        @(posedge clk); #1;
        checks++;
        if (ready_s[s] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end[%0d]: ready=%b expected 0", s, ready_s[s]);
        end
        do_txn(s, 1'b0, 32'h1C, 32'h0, "b2b_readback");
    endtask

    task automatic test_reset_mid();
        do_txn(1, 1'b1, 32'h30, 32'h0BADF00D, "pre_reset_wr");
        do_txn(1, 1'b0, 32'h14, 32'h0, "pre_reset_rd");
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b1; adr_s[1] = 32'h30; wdata_s[1] = 32'h11112222;
        @(posedge clk); #1;
        req_s[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            exp_rd[s] = 32'h0;
            checks++;
            if (ready_s[s] !== 1'b0 || err_s[s] !== 1'b0 || rdata_s[s] !== 32'h0) begin
                errors++;
                $display("FAIL mid_reset_out[%0d]: ready=%b err=%b rdata=%h expected 0", s, ready_s[s], err_s[s], rdata_s[s]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready_s[1] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_noready: ready=%b expected 0", ready_s[1]);
            end
        end
        do_txn(1, 1'b0, 32'h30, 32'h0, "post_reset_rd");
        checks++;
        if (rdata_s[1] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL aborted_write: rdata=%h expected 0badf00d", rdata_s[1]);
        end
    endtask

    task automatic test_random();
        int          s, k;
        bit          w;
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            s = int'($urandom_range(0, 1));
            k = int'($urandom_range(0, 19));
            w = 1'($urandom);
            if (k < 14) a = 32'($urandom_range(0, 31)) * 32'd4;
            else if (k < 17) a = (32'($urandom_range(0, 31)) * 32'd4) + 32'($urandom_range(1, 3));
            else a = $urandom | 32'h00001000;
            do_txn(s, w, a, $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_read_wait();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_latching();
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder that services the multicycle core's memory bus (address, write data, write strobe) and returns read data after a programmable number of wait states. It sits between the core's address mux / WriteData output and its instruction and data registers. It is the shared instruction/data memory, and it adds the request/ready handshake the controller FSM stalls on.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two, at least 2.
- `WAIT_CYCLES`, 2: wait states inserted between acceptance and response; range 0..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset; 0 resets the block immediately.
- `req` input 1: request valid; sampled only in IDLE.
- `we` input 1: 1 = write, 0 = read; sampled with `req`.
- `adr` input 32: byte address; sampled with `req`.
- `wdata` input 32: write data; sampled with `req`.
- `rdata` output 32: read data; registered and held between reads.
- `ready` output 1: one-cycle completion pulse.
- `err` output 1: valid only with `ready`; the request was misaligned or out of range.

## Operation
- FSM states:
  - IDLE: `req`=1 latches `adr`, `we` and `wdata`.
    - Goes to WAIT when `WAIT_CYCLES`>0.
    - Goes to RESP when `WAIT_CYCLES`=0.
  - WAIT: a 4-bit counter, loaded with `WAIT_CYCLES`-1 on acceptance, decrements each cycle. It goes to RESP on the edge where the counter is 0.
  - RESP: `ready`=1 for exactly this one cycle, then unconditionally back to IDLE.
- Latched request fields ignore changes to `adr`/`we`/`wdata`/`req` while in WAIT or RESP.
- Error check is done on the latched address:
  - misaligned: `adr[1:0]`≠0;
  - out of range: `adr[31:2]` ≥ `DEPTH_WORDS`.
- Array access happens on the edge entering RESP:
  - Read without error: `rdata` ← `mem[adr[31:2]]`.
  - Write without error: `mem[adr[31:2]]` ← `wdata`; `rdata` unchanged.
  - Any error: no array write, `rdata` ← 0, `err`=1 during RESP.
- `req` is not sampled in RESP. If `req` is still 1 in the following IDLE cycle, that is a new transaction. The requester must drop `req` the cycle after it sees `ready`.

## Timing
- Request sampled at edge E. `ready` is high in the cycle after edge E+`WAIT_CYCLES`. Total latency is `WAIT_CYCLES`+1 cycles.
- Minimum spacing between transactions: `WAIT_CYCLES`+2 cycles, because RESP always returns to IDLE.
- Read-after-write: a read issued after a write's `ready` returns the written data, since the write commits on the RESP entry edge.
- Reset values: state IDLE, counter 0, `ready`=0, `err`=0, `rdata`=0, latched fields 0. Array contents are not reset.
- Reset mid-operation: a transaction in WAIT is aborted with no write and no `ready`. After reset release, the first rising edge samples `req` in IDLE.
- `rdata` is held across writes, errors-free idle periods and WAIT cycles. It changes only on a read's RESP entry edge, or to 0 on an error.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - `WORD_W`=32;
  - `WAIT_W`=4;
  - a request struct holding `adr`, `we` and `wdata`.
- Sub-module `mem_array`: a synchronous single-port word RAM (we, addr, din, dout), `DEPTH_WORDS` deep. It reads and writes on the same edge; a read never overlaps a write.
- Top level holds the FSM, the wait counter, the request latch, the error check and the `rdata`/`err` registers.

## Test plan
- Read with wait states (`WAIT_CYCLES`=2): preload word 5 = 32'hDEADBEEF, then read `adr`=32'h14. Expected: `ready` high exactly one cycle, 3 cycles after the sample edge; `rdata`=32'hDEADBEEF; `err`=0.
- Write then read back (`WAIT_CYCLES`=0): write 32'h12345678 to 32'h20, then read 32'h20. Expected: each `ready` arrives 1 cycle after its request; the read returns 32'h12345678; `rdata` keeps its old value during the write.
- Misaligned access: write 32'hFFFFFFFF to 32'h22. Expected: `ready`=1 and `err`=1; `rdata`=0. A following read of 32'h20 still returns 32'h12345678.
- Out-of-range access (`DEPTH_WORDS`=1024): read 32'h00001000. Expected: `err`=1 with `ready`; `rdata`=0.
- Request latching and back-to-back: change `adr` and `we` during WAIT. Expected: the response reflects the original request. With `req` held high through `ready`, a second transaction starts in the IDLE cycle after RESP and its `ready` arrives `WAIT_CYCLES`+2 cycles after the first.
- Reset mid-transaction: a write to 32'h30 is in WAIT when `reset` goes to 0 for 1 cycle. Expected: outputs are 0 immediately; no `ready`; a later read of 32'h30 returns the prior contents.
